vga_anim_timer: RTL and testbench

Frame-synchronised animation controller that sits directly upstream of the sprite renderer. It consumes the beam position from the sync generator and produces animation state: eye blink, arm wave offsets and a frame counter. All outputs change only once per frame, at the start of vertical blank, so the active picture never tears. It replaces free-running clock-bit toggles with deterministic, frame-counted behaviour, and it adds a user-triggered blink request.

---
 rtl/vga_anim_pkg.sv | 25 ++
 rtl/vga_anim_timer_if.sv | 26 ++
 rtl/btn_sync_edge.sv | 28 ++
 rtl/vga_anim_timer.sv | 142 ++++++++++++++
 tb/tb_vga_anim_timer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_anim_pkg.sv
// Shared types and default timing for the frame-synchronised animation controller.
// Widths are fixed by the sync generator and sprite renderer interfaces.
package vga_anim_pkg;

  typedef enum logic {
    OPEN   = 1'b0,
    CLOSED = 1'b1
  } blink_state_t;

  typedef enum logic {
    RAISE = 1'b0,
    LOWER = 1'b1
  } wave_state_t;

  localparam int unsigned V_ACTIVE_DEF     = 480;
  localparam int unsigned BLINK_PERIOD_DEF = 180;
  localparam int unsigned BLINK_LEN_DEF    = 8;
  localparam int unsigned WAVE_MAX_DEF     = 30;
  localparam int unsigned WAVE_STEP_DEF    = 2;

  localparam int unsigned POS_W   = 10;
  localparam int unsigned COUNT_W = 8;
  localparam int unsigned DY_W    = 5;

endpackage

// File: rtl/vga_anim_timer_if.sv
// Beam position in, animation state out, between sync generator, controller and renderer.
// master = the video pipeline around the controller, slave = the controller itself.
interface vga_anim_timer_if;
  import vga_anim_pkg::*;

  logic [POS_W-1:0]   hpos;
  logic [POS_W-1:0]   vpos;
  logic               pause;
  logic               blink_btn;
  logic               frame_tick;
  logic [COUNT_W-1:0] frame_count;
  logic               eyes_closed;
  logic [DY_W-1:0]    arm_left_dy;
  logic [DY_W-1:0]    arm_right_dy;

  modport master (
    output hpos, vpos, pause, blink_btn,
    input  frame_tick, frame_count, eyes_closed, arm_left_dy, arm_right_dy
  );

  modport slave (
    input  hpos, vpos, pause, blink_btn,
    output frame_tick, frame_count, eyes_closed, arm_left_dy, arm_right_dy
  );

endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous push-button followed by a rising-edge pulse.
// The pulse is one clock wide and appears two clocks after the button is first sampled high.
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic sync_a;
  logic sync_b;
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      prev   <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      prev   <= sync_b;
    end
  end

  assign rise = sync_b & ~prev;

endmodule

// File: rtl/vga_anim_timer.sv
// Frame-counted eye blink and arm wave; all state moves only on the start-of-vblank tick.
//   state  | meaning
//   OPEN   | eyes open, blink_cnt counts frames toward the next automatic blink
//   CLOSED | eyes closed, blink_cnt counts frames of the current blink
//   RAISE  | arm_left_dy climbing toward WAVE_MAX
//   LOWER  | arm_left_dy falling toward 0
module vga_anim_timer
  import vga_anim_pkg::*;
#(
  parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
  parameter int unsigned BLINK_PERIOD = BLINK_PERIOD_DEF,
  parameter int unsigned BLINK_LEN    = BLINK_LEN_DEF,
  parameter int unsigned WAVE_MAX     = WAVE_MAX_DEF,
  parameter int unsigned WAVE_STEP    = WAVE_STEP_DEF
) (
  input logic             clk,
  input logic             reset,
  vga_anim_timer_if.slave bus
);

  localparam logic [COUNT_W-1:0] OPEN_LAST   = COUNT_W'(BLINK_PERIOD - 1);
  localparam logic [COUNT_W-1:0] CLOSED_LAST = COUNT_W'(BLINK_LEN - 1);
  localparam logic [DY_W-1:0]    MAX_DY      = DY_W'(WAVE_MAX);
  localparam logic [DY_W:0]      MAX_WIDE    = (DY_W+1)'(WAVE_MAX);
  localparam logic [DY_W:0]      STEP_WIDE   = (DY_W+1)'(WAVE_STEP);

  logic               tick_q;
  logic [COUNT_W-1:0] frame_cnt_q;
  blink_state_t       blink_q, blink_d;
  logic [COUNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_pend_q, blink_pend_d;
  wave_state_t        wave_q, wave_d;
  logic [DY_W-1:0]    dy_q, dy_d;
  logic               btn_rise;
  logic               tick_hit;
  logic               advance;
  logic [DY_W:0]      raise_sum;
  logic [DY_W:0]      lower_diff;

  btn_sync_edge u_btn (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.blink_btn),
    .rise  (btn_rise)
  );

  assign tick_hit = (bus.hpos == '0) && (bus.vpos == POS_W'(V_ACTIVE));
  assign advance  = tick_q & ~bus.pause;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q       <= 1'b0;
      frame_cnt_q  <= '0;
      blink_q      <= OPEN;
      blink_cnt_q  <= '0;
      blink_pend_q <= 1'b0;
      wave_q       <= RAISE;
      dy_q         <= '0;
    end else begin
      tick_q       <= tick_hit;
      if (tick_q) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
      blink_q      <= blink_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_pend_q <= blink_pend_d;
      wave_q       <= wave_d;
      dy_q         <= dy_d;
    end
  end

  // A button edge landing on the closing tick is swallowed by that blink.
  always_comb begin
    blink_d      = blink_q;
    blink_cnt_d  = blink_cnt_q;
    blink_pend_d = blink_pend_q;
    case (blink_q)
      OPEN: begin
        if (advance && (blink_pend_q || blink_cnt_q == OPEN_LAST)) begin
          blink_d      = CLOSED;
          blink_cnt_d  = '0;
          blink_pend_d = 1'b0;
        end else begin
          if (advance) begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
          if (btn_rise) begin
            blink_pend_d = 1'b1;
          end
        end
      end
      CLOSED: begin
        if (advance) begin
          if (blink_cnt_q == CLOSED_LAST) begin
            blink_d     = OPEN;
            blink_cnt_d = '0;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  // One extra bit of headroom so the clamp never sees a wrapped value.
  assign raise_sum  = {1'b0, dy_q} + STEP_WIDE;
  assign lower_diff = {1'b0, dy_q} - STEP_WIDE;

  always_comb begin
    wave_d = wave_q;
    dy_d   = dy_q;
    if (advance) begin
      case (wave_q)
        RAISE: begin
          if (raise_sum >= MAX_WIDE) begin
            dy_d   = MAX_DY;
            wave_d = LOWER;
          end else begin
            dy_d = raise_sum[DY_W-1:0];
          end
        end
        LOWER: begin
          if ({1'b0, dy_q} <= STEP_WIDE) begin
            dy_d   = '0;
            wave_d = RAISE;
          end else begin
            dy_d = lower_diff[DY_W-1:0];
          end
        end
      endcase
    end
  end

  always_comb begin
    bus.frame_tick   = tick_q;
    bus.frame_count  = frame_cnt_q;
    bus.eyes_closed  = (blink_q == CLOSED);
    bus.arm_left_dy  = dy_q;
    bus.arm_right_dy = MAX_DY - dy_q;
  end

endmodule

// File: tb/tb_vga_anim_timer.sv
// Randomised and directed stimulus for vga_anim_timer against a frame-level reference model.
// A shortened frame (8 x 14, vblank at line 12) keeps runs short.
module tb_vga_anim_timer;
  import vga_anim_pkg::*;

  localparam int H_TOTAL = 8;
  localparam int V_TOTAL = 14;
  localparam int VA      = 12;
  localparam int BP      = 4;
  localparam int BL      = 2;
  localparam int WM      = 5;
  localparam int WS      = 2;
  localparam int FRAME   = H_TOTAL * V_TOTAL;

  logic clk = 1'b0;
  logic reset = 1'b1;

  vga_anim_timer_if bus ();

  vga_anim_timer #(
    .V_ACTIVE     (VA),
    .BLINK_PERIOD (BP),
    .BLINK_LEN    (BL),
    .WAVE_MAX     (WM),
    .WAVE_STEP    (WS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  int   bh = 0;
  int   bv = 0;
  int   tick_seen = 0;
  logic btn_val = 1'b0;
  logic btn_prev = 1'b0;
  logic pause_val = 1'b0;
  logic rst_val = 1'b1;
  int   req_q[$];

  logic m_tick = 1'b0;
  int   m_fc = 0;
  int   m_closed_left = 0;
  int   m_open_age = 0;
  logic m_pend = 1'b0;
  int   m_wave_n = 0;
  int   tri_tab[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int m_dy();
    if (m_wave_n == 0) return 0;
    return tri_tab[(m_wave_n - 1) % tri_tab.size()];
  endfunction

  // Advances the model across one clock edge using the inputs held during the ended cycle.
  function automatic void model_edge();
    bit rise;
    bit was_open;
    bit closing;
    if (reset) begin
      m_tick = 1'b0;
      m_fc = 0;
      m_closed_left = 0;
      m_open_age = 0;
      m_pend = 1'b0;
      m_wave_n = 0;
      req_q.delete();
      return;
    end
    rise = 1'b0;
    while (req_q.size() > 0 && req_q[0] <= cyc - 1) begin
      if (req_q[0] == cyc - 1) rise = 1'b1;
      void'(req_q.pop_front());
    end
    was_open = (m_closed_left == 0);
    closing = 1'b0;
    if (m_tick) begin
      m_fc = (m_fc + 1) % 256;
      if (!bus.pause) begin
        m_wave_n++;
        if (was_open) begin
          if (m_pend || m_open_age == BP - 1) begin
            m_closed_left = BL;
            m_open_age = 0;
            m_pend = 1'b0;
            closing = 1'b1;
          end else begin
            m_open_age++;
          end
        end else begin
          m_closed_left--;
        end
      end
    end
    if (rise && was_open && !closing) m_pend = 1'b1;
    m_tick = (bh == 0 && bv == VA);
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    bh++;
    if (bh == H_TOTAL) begin
      bh = 0;
      bv++;
      if (bv == V_TOTAL) bv = 0;
    end
    bus.hpos = 10'(bh);
    bus.vpos = 10'(bv);
    // Synchroniser plus edge register: the pulse is live two cycles after the press is driven.
    if (btn_val && !btn_prev) req_q.push_back(cyc + 2);
    btn_prev = btn_val;
    bus.blink_btn = btn_val;
    bus.pause = pause_val;
    reset = rst_val;
    @(negedge clk);
    if (bus.frame_tick === 1'b1) tick_seen++;
    chk("frame_tick",   32'(bus.frame_tick),   32'(m_tick));
    chk("frame_count",  32'(bus.frame_count),  m_fc);
    chk("eyes_closed",  32'(bus.eyes_closed),  (m_closed_left != 0) ? 1 : 0);
    chk("arm_left_dy",  32'(bus.arm_left_dy),  m_dy());
    chk("arm_right_dy", 32'(bus.arm_right_dy), WM - m_dy());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // mode 0: eyes open, nothing pending, beam at (0,2)
  // mode 1: two cycles before a tick that will auto-close the eyes
  // mode 2: like mode 0 but with the arm at 2 on its way up
  task automatic seek(input int mode, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 * FRAME; i++) begin
      step();
      if (mode == 0 && bh == 0 && bv == 2 && m_closed_left == 0 && !m_pend) begin
        ok = 1'b1;
        break;
      end
      if (mode == 1 && bh == H_TOTAL - 2 && bv == VA - 1 && m_closed_left == 0 &&
          m_open_age == BP - 1 && !m_pend) begin
        ok = 1'b1;
        break;
      end
      if (mode == 2 && bh == 0 && bv == 2 && m_closed_left == 0 && !m_pend && m_dy() == 2) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("seek_timeout", 32'(mode), 32'hFFFF_FFFF);
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    bit ok;
    int v;
    bit up;
    int exp_arm;
    int exp_fc;
    int p;
    int len;

    // Arm trajectory after each unpaused tick, one full period.
    v = 0;
    up = 1'b1;
    do begin
      if (up) begin
        v = (v + WS > WM) ? WM : v + WS;
        if (v == WM) up = 1'b0;
      end else begin
        v = (v - WS < 0) ? 0 : v - WS;
        if (v == 0) up = 1'b1;
      end
      tri_tab.push_back(v);
    end while (!(v == 0 && up));

    bus.hpos = '0;
    bus.vpos = '0;
    bus.pause = 1'b0;
    bus.blink_btn = 1'b0;

    run(4);
    rst_val = 1'b0;
    tick_seen = 0;

    run(3 * FRAME);
    chk("ticks_after_3_frames", 32'(tick_seen), 3);
    chk("count_after_3_frames", 32'(bus.frame_count), 3);

    run(8 * FRAME);
    chk("auto_blink_tick11", 32'(bus.eyes_closed), 1);
    chk("wave_tick11", 32'(bus.arm_left_dy), 1);
    chk("wave_right_tick11", 32'(bus.arm_right_dy), 4);

    seek(0, ok);
    if (ok) begin
      btn_val = 1'b1;
      run(5);
      btn_val = 1'b0;
      run(FRAME);
      chk("button_blink", 32'(bus.eyes_closed), 1);
      btn_val = 1'b1;
      run(5);
      btn_val = 1'b0;
      run(2 * FRAME);
      chk("button_blink_len", 32'(bus.eyes_closed), 0);
      run(FRAME);
      chk("closed_press_ignored", 32'(bus.eyes_closed), 0);
    end

    seek(0, ok);
    if (ok) begin
      exp_arm = m_dy();
      exp_fc = (m_fc + 10) % 256;
      pause_val = 1'b1;
      run(3);
      btn_val = 1'b1;
      run(3);
      btn_val = 1'b0;
      run(10 * FRAME - 6);
      chk("pause_arm_hold", 32'(bus.arm_left_dy), exp_arm);
      chk("pause_eyes_hold", 32'(bus.eyes_closed), 0);
      chk("pause_count_runs", 32'(bus.frame_count), exp_fc);
      pause_val = 1'b0;
      run(FRAME);
      chk("pause_pending_blink", 32'(bus.eyes_closed), 1);
    end

    seek(1, ok);
    if (ok) begin
      btn_val = 1'b1;
      run(3);
      btn_val = 1'b0;
      run(3 * FRAME + 10);
      chk("edge_on_close_absorbed", 32'(bus.eyes_closed), 0);
    end

    for (int f = 0; f < 30; f++) begin
      pause_val = ($urandom_range(0, 3) == 0);
      p = int'($urandom_range(0, FRAME - 8));
      len = int'($urandom_range(1, 6));
      run(p);
      btn_val = ($urandom_range(0, 1) == 1);
      run(len);
      btn_val = 1'b0;
      run(FRAME - p - len);
    end
    pause_val = 1'b0;

    seek(2, ok);
    if (ok) begin
      btn_val = 1'b1;
      run(2);
      btn_val = 1'b0;
      run(FRAME);
      chk("pre_reset_eyes", 32'(bus.eyes_closed), 1);
      chk("pre_reset_arm", 32'(bus.arm_left_dy), 4);
      rst_val = 1'b1;
      step();
      rst_val = 1'b0;
      step();
      chk("reset_eyes", 32'(bus.eyes_closed), 0);
      chk("reset_arm_left", 32'(bus.arm_left_dy), 0);
      chk("reset_arm_right", 32'(bus.arm_right_dy), WM);
      chk("reset_count", 32'(bus.frame_count), 0);
      chk("reset_tick", 32'(bus.frame_tick), 0);
      run(2 * FRAME);
      chk("count_after_reset", 32'(bus.frame_count), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
